// File: rtl/dinorun_pkg.sv
// dinorun_pkg: shared scheduler state type, obstacle slot ids and slot rotation helper
package dinorun_pkg;
  typedef enum logic [1:0] {IDLE, COOL, ARMED, FIRE} sched_state_t;
  localparam logic [1:0] SlotCactus0 = 2'd0;
  localparam logic [1:0] SlotCactus1 = 2'd1;
  localparam logic [1:0] SlotBird = 2'd2;
  localparam int NumSlots = 3;
  function automatic logic [1:0] slot_next(input logic [1:0] s);
    return s == SlotBird ? SlotCactus0 : s + 2'd1;
  endfunction
endpackage

// File: rtl/obstacle_slot_picker.sv
// obstacle_slot_picker: first free slot searching from pref in rotating order
module obstacle_slot_picker
  import dinorun_pkg::*;
(
  input  logic [1:0]          pref,
  input  logic [NumSlots-1:0] busy,
  output logic                found,
  output logic [1:0]          slot
);
  logic [1:0] s1, s2;
  assign s1 = slot_next(pref);
  assign s2 = slot_next(s1);
  assign found = !busy[pref] || !busy[s1] || !busy[s2];
  assign slot = !busy[pref] ? pref : !busy[s1] ? s1 : !busy[s2] ? s2 : SlotCactus0;
endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: frame-paced obstacle spawn FSM with difficulty-scaled gap
module obstacle_scheduler
  import dinorun_pkg::*;
#(
  parameter int MinGap = 40,
  parameter int GapFloor = 16,
  parameter int GapStep = 4,
  parameter int LevelFrames = 256,
  parameter int RandGapBits = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                run_i,
  input  logic                frame_i,
  input  logic [15:0]         rand_i,
  input  logic [NumSlots-1:0] busy_i,
  output logic                next_o,
  output logic [NumSlots-1:0] spawn_o,
  output logic [1:0]          variant_o,
  output logic [7:0]          gap_o
);
  localparam int LW = $clog2(LevelFrames + 1);
  sched_state_t state;
  logic [7:0] cnt, base, load;
  logic [LW-1:0] lvl;
  logic [1:0] slot_q, var_q, pref, slot;
  logic found, frame_run, lvl_wrap, unused_rand;
  assign unused_rand = ^rand_i;
  assign load = base + 8'(rand_i[RandGapBits-1:0]);
  assign pref = rand_i[1:0] == 2'b00 ? SlotBird : rand_i[1:0] == 2'b10 ? SlotCactus1 : SlotCactus0;
  assign frame_run = frame_i && state != IDLE;
  assign lvl_wrap = lvl == LW'(LevelFrames - 1);
  obstacle_slot_picker picker (
    .pref (pref),
    .busy (busy_i),
    .found(found),
    .slot (slot)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      lvl <= '0;
      base <= 8'(MinGap);
      slot_q <= '0;
      var_q <= '0;
    end else if (!run_i) begin
      state <= IDLE;
      cnt <= '0;
      lvl <= '0;
      base <= 8'(MinGap);
    end else begin
      if (frame_run) begin
        lvl <= lvl_wrap ? '0 : lvl + LW'(1);
        if (lvl_wrap) base <= base >= 8'(GapFloor + GapStep) ? base - 8'(GapStep) : 8'(GapFloor);
      end
      case (state)
        IDLE: begin
          state <= COOL;
          cnt <= load;
        end
        COOL: if (frame_i) begin
          state <= cnt <= 8'd1 ? ARMED : COOL;
          cnt <= cnt == 8'd0 ? cnt : cnt - 8'd1;
        end
        ARMED: if (frame_i && found) begin
          state <= FIRE;
          slot_q <= slot;
          var_q <= rand_i[3:2];
        end
        default: begin
          state <= COOL;
          cnt <= load;
        end
      endcase
    end
  end
  assign spawn_o = (state == FIRE && run_i) ? 3'b001 << slot_q : 3'b000;
  assign variant_o = spawn_o != 3'b000 ? var_q : 2'b00;
  assign next_o = frame_run || state == FIRE;
  assign gap_o = base;
endmodule
